// File: rtl/fetch_aligner.sv
// Word-aligned fetch sequencer feeding a three-slot halfword buffer that presents
// one 16-bit (zero-extended) or 32-bit instruction per cycle to the decoder.
module fetch_aligner #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_fetch_req,
   output logic [31:0] o_fetch_addr,
   input  logic        i_fetch_valid,
   input  logic [31:0] i_fetch_data,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_stall,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc,
   output logic        o_instr_valid,
   output logic        o_instr_compressed,
   output logic [1:0]  o_dbg_state
);

   // Handshakes: a fetch is a one-cycle o_fetch_req pulse answered later by exactly one
   // i_fetch_valid strobe; the decoder takes o_instr in any cycle with
   // o_instr_valid && !i_stall, otherwise the instruction is held unchanged.

   // State bits read directly as {drop, pend}.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_WAIT    = 2'b01,
      ST_DISCARD = 2'b11
   } ctl_state_t;

   ctl_state_t  state, state_next;
   logic [47:0] par_buf, buf_next, shifted, merged;
   logic [1:0]  cnt, cnt_next, cnt_post, cons_n, app_n;
   logic [31:0] head_pc, fetch_pc, app_word;
   logic        skip;
   logic        head_is32, enough, consume, accept;
   logic        unused_bits;

   assign unused_bits = i_redirect_pc[0];

   assign head_is32          = (par_buf[1:0] == 2'b11);
   assign enough             = head_is32 ? (cnt >= 2'd2) : (cnt >= 2'd1);
   assign o_instr_valid      = enough && !i_redirect && !i_rst;
   assign o_instr            = head_is32 ? par_buf[31:0] : {16'h0000, par_buf[15:0]};
   assign o_instr_compressed = !head_is32;
   assign o_instr_pc         = head_pc;
   assign o_fetch_addr       = fetch_pc;
   assign o_dbg_state        = state;

   assign consume  = o_instr_valid && !i_stall;
   assign cons_n   = consume ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;
   assign cnt_post = cnt - cons_n;

   assign o_fetch_req = (state == ST_IDLE) && !i_redirect && !i_rst && (cnt_post <= 2'd1);

   // A response while idle can only be an orphan from before reset; it is kept.
   assign accept   = i_fetch_valid && (state != ST_DISCARD);
   assign app_word = skip ? {16'h0000, i_fetch_data[31:16]} : i_fetch_data;
   assign app_n    = skip ? 2'd1 : 2'd2;

   always_comb begin
      shifted = par_buf;
      case (cons_n)
         2'd1:    shifted = {16'h0000, par_buf[47:16]};
         2'd2:    shifted = {32'h0000_0000, par_buf[47:32]};
         default: shifted = par_buf;
      endcase
   end

   // Appends land right after the surviving parcels; a request is only made when at
   // most one parcel survives, so the buffer never overflows.
   always_comb begin
      merged = shifted;
      case (cnt_post)
         2'd0:    merged = {16'h0000, app_word};
         2'd1:    merged = {app_word, shifted[15:0]};
         2'd2:    merged = {app_word[15:0], shifted[31:0]};
         default: merged = shifted;
      endcase
      buf_next = accept ? merged : shifted;
      cnt_next = accept ? (cnt_post + app_n) : cnt_post;
   end

   always_comb begin
      state_next = state;
      if (i_redirect) begin
         state_next = ((state != ST_IDLE) && !i_fetch_valid) ? ST_DISCARD : ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (o_fetch_req) state_next = ST_WAIT;
            ST_WAIT:    if (i_fetch_valid) state_next = ST_IDLE;
            ST_DISCARD: if (i_fetch_valid) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         par_buf  <= '0;
         cnt      <= 2'd0;
         head_pc  <= RESET_VECTOR;
         fetch_pc <= RESET_VECTOR;
         skip     <= 1'b0;
      end else if (i_redirect) begin
         cnt      <= 2'd0;
         head_pc  <= {i_redirect_pc[31:1], 1'b0};
         fetch_pc <= {i_redirect_pc[31:2], 2'b00};
         skip     <= i_redirect_pc[1];
      end else begin
         par_buf <= buf_next;
         cnt     <= cnt_next;
         head_pc <= head_pc + {29'd0, cons_n, 1'b0};
         if (o_fetch_req) fetch_pc <= fetch_pc + 32'd4;
         if (accept)      skip     <= 1'b0;
      end
   end

endmodule
